// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg                                                                    |
// | Shared instruction-field layout, opcodes and sequencer states.             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int IR_W    = 16;
    localparam int OP_LSB  = 0;
    localparam int OP_W    = 4;
    localparam int IMM_BIT = 4;
    localparam int RX_LSB  = 5;
    localparam int RY_LSB  = 8;

    typedef enum logic [3:0] {
        OP_MV   = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_CMP  = 4'h3,
        OP_LD   = 4'h4,
        OP_ST   = 4'h5,
        OP_MVHI = 4'h6,
        OP_JR   = 4'h8,
        OP_JZ   = 4'h9,
        OP_JN   = 4'hA,
        OP_CALL = 4'hC
    } opcode_e;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    // Unused opcode slot: reads nothing, writes nothing, never branches.
    localparam logic [IR_W-1:0] NOP_IR = 16'h0007;

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == OP_JR) || (op == OP_JZ) || (op == OP_JN) || (op == OP_CALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_hazard_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_hazard_control_if                                                      |
// | Datapath <-> pipeline sequencer bundle (IRs in, load/select/valid out).    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface cpu_hazard_control_if #(
    parameter int CNT_W = 16
);
    logic [cpu_pkg::IR_W-1:0] i_ir_dc;
    logic [cpu_pkg::IR_W-1:0] i_ir_ex;
    logic [cpu_pkg::IR_W-1:0] i_ir_wr;
    logic                     i_br_taken;
    logic                     o_pc_ld;
    logic                     o_pc_sel;
    logic                     o_pc_dc_ld;
    logic                     o_ir_ex_ld;
    logic                     o_ir_ex_sel;
    logic                     o_v_dc;
    logic                     o_v_ex;
    logic                     o_v_wr;
    logic                     o_stall;
    logic                     o_flush;
    logic [CNT_W-1:0]         o_stall_cnt;
    logic [CNT_W-1:0]         o_flush_cnt;

    modport slave (
        input  i_ir_dc, i_ir_ex, i_ir_wr, i_br_taken,
        output o_pc_ld, o_pc_sel, o_pc_dc_ld, o_ir_ex_ld, o_ir_ex_sel,
        output o_v_dc, o_v_ex, o_v_wr, o_stall, o_flush, o_stall_cnt, o_flush_cnt
    );

    modport master (
        output i_ir_dc, i_ir_ex, i_ir_wr, i_br_taken,
        input  o_pc_ld, o_pc_sel, o_pc_dc_ld, o_ir_ex_ld, o_ir_ex_sel,
        input  o_v_dc, o_v_ex, o_v_wr, o_stall, o_flush, o_stall_cnt, o_flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cpu_reg_use_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_reg_use_decode                                                         |
// | Combinational register-usage decode: which of Rx/Ry are read, what is      |
// | written. Rev 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module cpu_reg_use_decode
    import cpu_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic [IR_W-1:0]          i_ir,
    output logic                     o_rd_x,
    output logic                     o_rd_y,
    output logic                     o_wr_en,
    output logic [$clog2(NREG)-1:0]  o_wr_idx
);
    localparam int IDX_W = $clog2(NREG);

    logic [OP_W-1:0]  w_op;
    logic             w_imm;
    logic [IDX_W-1:0] w_rx;
    logic             w_unused_hi;

    assign w_op        = i_ir[OP_LSB +: OP_W];
    assign w_imm       = i_ir[IMM_BIT];
    assign w_rx        = i_ir[RX_LSB +: IDX_W];
    assign w_unused_hi = ^i_ir[IR_W-1:RX_LSB+IDX_W];

    always_comb begin
        o_rd_x   = 1'b0;
        o_rd_y   = 1'b0;
        o_wr_en  = 1'b0;
        o_wr_idx = w_rx;
        case (w_op)
            OP_MV:          begin o_wr_en = 1'b1; o_rd_y = ~w_imm; end
            OP_ADD, OP_SUB: begin o_wr_en = 1'b1; o_rd_x = 1'b1; o_rd_y = ~w_imm; end
            OP_CMP:         begin o_rd_x = 1'b1; o_rd_y = ~w_imm; end
            OP_LD:          begin o_wr_en = 1'b1; o_rd_y = 1'b1; end
            OP_ST:          begin o_rd_x = 1'b1; o_rd_y = 1'b1; end
            OP_MVHI:        begin o_wr_en = 1'b1; o_rd_x = 1'b1; end
            OP_JR, OP_JZ, OP_JN: o_rd_x = ~w_imm;
            // Link register is the top architectural register.
            OP_CALL:        begin o_wr_en = 1'b1; o_wr_idx = IDX_W'(NREG-1); o_rd_x = ~w_imm; end
            default:        ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_hazard_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_hazard_control                                                         |
// | F/DC/EX/WR sequencer: valid tracking, RAW stall + EX bubble, branch squash.|
// | Optional perf counters when CPU_HAZ_PERF_EN is defined.                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module cpu_hazard_control
    import cpu_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    cpu_hazard_control_if.slave  bus
);
    localparam int IDX_W = $clog2(NREG);
    localparam int N_STG = 3;

    state_e           r_state;
    logic             r_v_dc, r_v_ex, r_v_wr;
    logic [IR_W-1:0]  w_ir     [N_STG];
    logic [N_STG-1:0] w_rd_x, w_rd_y, w_wr_en;
    logic [IDX_W-1:0] w_wr_idx [N_STG];
    logic [IDX_W-1:0] w_dc_rx, w_dc_ry;
    logic             w_ex_hit, w_wr_hit, w_hazard, w_flush, w_unused_dec;
    logic             w_stall_out, w_flush_out;

    assign w_ir[0] = bus.i_ir_dc;
    assign w_ir[1] = bus.i_ir_ex;
    assign w_ir[2] = bus.i_ir_wr;

    generate
        for (genvar g = 0; g < N_STG; g++) begin : g_dec
            cpu_reg_use_decode #(.NREG(NREG)) u_dec (
                .i_ir     (w_ir[g]),
                .o_rd_x   (w_rd_x[g]),
                .o_rd_y   (w_rd_y[g]),
                .o_wr_en  (w_wr_en[g]),
                .o_wr_idx (w_wr_idx[g])
            );
        end
    endgenerate

    assign w_unused_dec = ^{w_rd_x[2:1], w_rd_y[2:1], w_wr_en[0], w_wr_idx[0]};
    assign w_dc_rx      = w_ir[0][RX_LSB +: IDX_W];
    assign w_dc_ry      = w_ir[0][RY_LSB +: IDX_W];

    // No RF write-through, so a producer still in WR blocks the reader as well.
    assign w_ex_hit = r_v_ex & w_wr_en[1] & ((w_rd_x[0] & (w_wr_idx[1] == w_dc_rx)) |
                                             (w_rd_y[0] & (w_wr_idx[1] == w_dc_ry)));
    assign w_wr_hit = r_v_wr & w_wr_en[2] & ((w_rd_x[0] & (w_wr_idx[2] == w_dc_rx)) |
                                             (w_rd_y[0] & (w_wr_idx[2] == w_dc_ry)));
    assign w_hazard = r_v_dc & (w_ex_hit | w_wr_hit);
    assign w_flush  = r_v_ex & is_branch(w_ir[1][OP_LSB +: OP_W]) & bus.i_br_taken;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_BOOT;
            r_v_dc  <= 1'b0;
            r_v_ex  <= 1'b0;
            r_v_wr  <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_v_dc  <= 1'b1;
                    r_v_ex  <= 1'b0;
                    r_v_wr  <= 1'b0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_flush) begin
                        r_v_dc  <= 1'b0;
                        r_v_ex  <= 1'b0;
                        r_v_wr  <= 1'b1;
                        r_state <= S_FLUSH;
                    end else if (w_hazard) begin
                        r_v_ex <= 1'b0;
                        r_v_wr <= r_v_ex;
                    end else begin
                        r_v_dc <= 1'b1;
                        r_v_ex <= r_v_dc;
                        r_v_wr <= r_v_ex;
                    end
                end
                S_FLUSH: begin
                    r_v_dc  <= 1'b1;
                    r_v_ex  <= r_v_dc;
                    r_v_wr  <= r_v_ex;
                    r_state <= S_RUN;
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    // BOOT loads are qualified by reset so the held-in-reset outputs read idle.
    always_comb begin
        bus.o_pc_ld     = 1'b0;
        bus.o_pc_sel    = 1'b0;
        bus.o_pc_dc_ld  = 1'b0;
        bus.o_ir_ex_ld  = 1'b0;
        bus.o_ir_ex_sel = 1'b1;
        w_stall_out     = 1'b0;
        w_flush_out     = 1'b0;
        case (r_state)
            S_BOOT: begin
                bus.o_pc_ld    = i_reset;
                bus.o_pc_dc_ld = i_reset;
                bus.o_ir_ex_ld = i_reset;
            end
            S_RUN: begin
                if (w_flush) begin
                    w_flush_out    = 1'b1;
                    bus.o_pc_sel   = 1'b1;
                    bus.o_pc_ld    = 1'b1;
                    bus.o_pc_dc_ld = 1'b1;
                    bus.o_ir_ex_ld = 1'b1;
                end else if (w_hazard) begin
                    w_stall_out    = 1'b1;
                    bus.o_ir_ex_ld = 1'b1;
                end else begin
                    bus.o_pc_ld     = 1'b1;
                    bus.o_pc_dc_ld  = 1'b1;
                    bus.o_ir_ex_ld  = 1'b1;
                    bus.o_ir_ex_sel = 1'b0;
                end
            end
            S_FLUSH: begin
                bus.o_pc_ld    = 1'b1;
                bus.o_pc_dc_ld = 1'b1;
                bus.o_ir_ex_ld = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.o_stall = w_stall_out;
    assign bus.o_flush = w_flush_out;
    assign bus.o_v_dc  = r_v_dc;
    assign bus.o_v_ex  = r_v_ex;
    assign bus.o_v_wr  = r_v_wr;

`ifdef CPU_HAZ_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_out && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_out && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.o_stall_cnt = r_stall_cnt;
    assign bus.o_flush_cnt = r_flush_cnt;
`else
    assign bus.o_stall_cnt = '0;
    assign bus.o_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_hazard_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_hazard_control                                                      |
// | Directed bench: small fetch/IR pipeline model around the sequencer.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_cpu_hazard_control;
    import cpu_pkg::*;

    localparam int CNT_W = 16;
`ifdef CPU_HAZ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [15:0]     mem [32];
    int              pc;
    int              br_target;
    int              n_pass  = 0;
    int              n_total = 0;

    always #5 clk = ~clk;

    cpu_hazard_control_if #(.CNT_W(CNT_W)) hz ();

    cpu_hazard_control #(.NREG(8), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (reset_n),
        .bus     (hz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic imm,
                                        input logic [2:0] rx, input logic [2:0] ry);
        return {5'b0, ry, rx, imm, op};
    endfunction

    // {pc_ld, pc_sel, pc_dc_ld, ir_ex_ld, ir_ex_sel, stall, flush, v_dc, v_ex, v_wr}
    function automatic logic [9:0] outs();
        return {hz.o_pc_ld, hz.o_pc_sel, hz.o_pc_dc_ld, hz.o_ir_ex_ld, hz.o_ir_ex_sel,
                hz.o_stall, hz.o_flush, hz.o_v_dc, hz.o_v_ex, hz.o_v_wr};
    endfunction

    // One clock: datapath registers react to the load/select strobes seen before the edge.
    task automatic cycle();
        logic pcld, pcsel, dcld, exld, exsel;
        pcld  = hz.o_pc_ld;
        pcsel = hz.o_pc_sel;
        dcld  = hz.o_pc_dc_ld;
        exld  = hz.o_ir_ex_ld;
        exsel = hz.o_ir_ex_sel;
        @(posedge clk);
        #1;
        hz.i_br_taken = 1'b0;
        hz.i_ir_wr    = hz.i_ir_ex;
        if (exld) hz.i_ir_ex = exsel ? NOP_IR : hz.i_ir_dc;
        if (dcld) hz.i_ir_dc = mem[pc & 31];
        if (pcld) pc = pcsel ? br_target : pc + 1;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int i = 0; i < 32; i++) mem[i] = NOP_IR;
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
    endtask

    // Leaves the bench in cycle 1 (BOOT) after reset release.
    task automatic start(input string tag);
        reset_n       = 1'b0;
        hz.i_br_taken = 1'b0;
        hz.i_ir_dc    = NOP_IR;
        hz.i_ir_ex    = NOP_IR;
        hz.i_ir_wr    = NOP_IR;
        pc            = 0;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_reset_outs"}, 32'(outs()), 32'b0000100000);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        br_target = 10;

        // Boot sequence with an all-NOP program
        load(NOP_IR, NOP_IR, NOP_IR);
        start("boot");
        check("boot_c1", 32'(outs()), 32'b1011100000);
        cycle();
        check("boot_c2", 32'(outs()), 32'b1011000100);
        cycle();
        check("boot_c3", 32'(outs()), 32'b1011000110);
        cycle();
        check("boot_c4", 32'(outs()), 32'b1011000111);
        check("boot_stall_cnt", 32'(hz.o_stall_cnt), 32'd0);

        // add r1,r2 ; add r3,r1 -> EX stall then WR stall
        load(enc(OP_ADD, 1'b0, 3'd1, 3'd2), enc(OP_ADD, 1'b0, 3'd3, 3'd1), NOP_IR);
        start("raw");
        cycle();
        cycle();
        check("raw_ex_stall", 32'(outs()), 32'b0001110110);
        cycle();
        check("raw_wr_stall", 32'(outs()), 32'b0001110101);
        cycle();
        check("raw_resume", 32'(outs()), 32'b1011000100);
        cycle();
        check("raw_ex_ir", 32'(hz.i_ir_ex), 32'(enc(OP_ADD, 1'b0, 3'd3, 3'd1)));
        check("raw_v_ex", 32'(hz.o_v_ex), 32'd1);
        check("raw_stall_cnt", 32'(hz.o_stall_cnt), PERF ? 32'd2 : 32'd0);

        // ld r4,[r1] ; nop ; st r0,[r4] -> exactly one stall, in cycle 4
        load(enc(OP_LD, 1'b0, 3'd4, 3'd1), NOP_IR, enc(OP_ST, 1'b0, 3'd0, 3'd4));
        start("ldst");
        begin
            int n_st;
            int first;
            n_st  = 0;
            first = 0;
            for (int c = 1; c <= 8; c++) begin
                if (hz.o_stall) begin
                    n_st++;
                    if (first == 0) first = c;
                end
                cycle();
            end
            check("ldst_stall_count", 32'(n_st), 32'd1);
            check("ldst_stall_cycle", 32'(first), 32'd4);
        end

        // mv r5,r1 ; jz #imm ; add r6,r5 -> taken branch with hazard in DC
        load(enc(OP_MV, 1'b0, 3'd5, 3'd1), enc(OP_JZ, 1'b1, 3'd0, 3'd0), enc(OP_ADD, 1'b0, 3'd6, 3'd5));
        mem[10] = enc(OP_MV, 1'b1, 3'd2, 3'd0);
        start("br");
        cycle();
        cycle();
        cycle();
        check("br_hazard_untaken", 32'(hz.o_stall), 32'd1);
        hz.i_br_taken = 1'b1;
        #1;
        check("br_flush_outs", 32'(outs()), 32'b1111101111);
        cycle();
        check("br_refill", 32'(outs()), 32'b1011100001);
        cycle();
        check("br_target_run", 32'(outs()), 32'b1011000100);
        check("br_target_ir", 32'(hz.i_ir_dc), 32'(enc(OP_MV, 1'b1, 3'd2, 3'd0)));
        check("br_flush_cnt", 32'(hz.o_flush_cnt), PERF ? 32'd1 : 32'd0);

        // Immediate forms: add reads Rx regardless, mv #imm reads nothing
        load(enc(OP_ADD, 1'b1, 3'd1, 3'd0), enc(OP_ADD, 1'b1, 3'd1, 3'd0), NOP_IR);
        start("imm_a");
        cycle();
        cycle();
        check("imm_add_rx_stall", 32'(hz.o_stall), 32'd1);
        load(enc(OP_ADD, 1'b1, 3'd1, 3'd0), enc(OP_MV, 1'b1, 3'd2, 3'd1), NOP_IR);
        start("imm_b");
        cycle();
        cycle();
        check("imm_mv_no_stall", 32'(hz.o_stall), 32'd0);

        // Asynchronous reset in the middle of a stall
        load(enc(OP_ADD, 1'b0, 3'd1, 3'd2), enc(OP_ADD, 1'b0, 3'd3, 3'd1), NOP_IR);
        start("arst");
        cycle();
        cycle();
        cycle();
        check("arst_pre_stall", 32'(hz.o_stall), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_outs", 32'(outs()), 32'b0000100000);
        check("arst_stall_cnt", 32'(hz.o_stall_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
